// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states and
// the byte-lane store/load helpers that the core's forwarding logic also uses.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_IO_WAIT,
        ST_RESP
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } access_size_t;

    // Unsupported encodings (011, 110, 111) fall through to a full word.
    function automatic access_size_t access_size(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return SZ_BYTE;
            F3_H, F3_HU: return SZ_HALF;
            default:     return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (access_size(funct3))
            SZ_BYTE: return 1'b0;
            SZ_HALF: return offset[0];
            default: return offset != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] funct3, input logic [1:0] offset);
        case (access_size(funct3))
            SZ_BYTE: return 4'b0001 << offset;
            SZ_HALF: return offset[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] wdata);
        case (access_size(funct3))
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] funct3, input logic [1:0] offset,
                                                 input logic [31:0] word);
        logic [31:0] shifted;
        shifted = word >> {offset, 3'b000};
        case (funct3)
            F3_B:    return {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   return {24'h000000, shifted[7:0]};
            F3_H:    return {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   return {16'h0000, shifted[15:0]};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/dataram_be.sv
// Synchronous single-port data RAM with per-byte write enables and a
// registered read port; read data holds until the next enabled access.
module dataram_be #(
  parameter int RAM_WORDS = 16384,
  parameter     INIT_FILE = "DATARAM.hex"
) (
  input  logic                         clk,
  input  logic                         en,
  input  logic [3:0]                   we,
  input  logic [$clog2(RAM_WORDS)-1:0] addr,
  input  logic [31:0]                  wdata,
  output logic [31:0]                  rdata
);

  logic [31:0] mem [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (we[lane]) begin
          mem[addr][lane*8 +: 8] <= wdata[lane*8 +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage of the RV32I pipeline: valid/ready request/response front end
// over a byte-enabled data RAM and a wait-stated IO port with timeout.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int RAM_WORDS  = 16384,
    parameter int IO_BIT     = 22,
    parameter int IO_TIMEOUT = 255,
    parameter     INIT_FILE  = "DATARAM.hex"
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rdId,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rdId,
    output logic        rsp_err,
    output logic [31:0] IO_mem_addr,
    output logic [31:0] IO_mem_wdata,
    output logic        IO_mem_wr,
    output logic        IO_mem_rd,
    input  logic [31:0] IO_mem_rdata,
    input  logic        IO_mem_ready
);

    localparam int IDX_W = $clog2(RAM_WORDS);
    localparam int CNT_W = 16;

    lsu_state_t  state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;
    logic        store_q;
    logic [4:0]  rdId_q;
    logic [31:0] io_rdata_q;
    logic        err_q;
    logic [CNT_W-1:0] io_cnt;

    logic        misaligned;
    logic        is_io;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_rdata;

    assign misaligned   = is_misaligned(funct3_q, addr_q[1:0]);
    assign is_io        = addr_q[IO_BIT];
    assign ram_en       = (state == ST_ACCESS) && !misaligned && !is_io;
    assign ram_we       = store_q ? store_mask(funct3_q, addr_q[1:0]) : 4'b0000;
    assign req_ready    = (state == ST_IDLE);
    assign IO_mem_addr  = addr_q;
    assign IO_mem_wdata = wdata_q;

    dataram_be #(
        .RAM_WORDS (RAM_WORDS),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (addr_q[2 +: IDX_W]),
        .wdata (store_lanes(funct3_q, wdata_q)),
        .rdata (ram_rdata)
    );

    // Request and IO read data are pure datapath and carry no reset.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req_valid) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
            store_q  <= req_store;
            rdId_q   <= req_rdId;
        end
        if (state == ST_IO_WAIT && IO_mem_ready) begin
            io_rdata_q <= IO_mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_rdId  <= '0;
            rsp_err   <= 1'b0;
            IO_mem_wr <= 1'b0;
            IO_mem_rd <= 1'b0;
            io_cnt    <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    err_q <= misaligned;
                    if (misaligned || !is_io) begin
                        state <= ST_RESP;
                    end else begin
                        IO_mem_wr <= store_q;
                        IO_mem_rd <= !store_q;
                        io_cnt    <= '0;
                        state     <= ST_IO_WAIT;
                    end
                end
                ST_IO_WAIT: begin
                    if (IO_mem_ready || io_cnt == CNT_W'(IO_TIMEOUT - 1)) begin
                        err_q     <= !IO_mem_ready;
                        IO_mem_wr <= 1'b0;
                        IO_mem_rd <= 1'b0;
                        state     <= ST_RESP;
                    end else begin
                        io_cnt <= io_cnt + 16'd1;
                    end
                end
                ST_RESP: begin
                    // First RESP cycle formats the result; afterwards hold until accepted.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= err_q;
                        rsp_rdId  <= rdId_q;
                        if (err_q || store_q) begin
                            rsp_data <= '0;
                        end else if (is_io) begin
                            rsp_data <= io_rdata_q;
                        end else begin
                            rsp_data <= load_extract(funct3_q, addr_q[1:0], ram_rdata);
                        end
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random RAM/IO
// traffic compared against a word-array reference model.
module tb_load_store_unit;

    localparam int RAM_WORDS  = 256;
    localparam int IO_BIT     = 22;
    localparam int IO_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b010;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rdId = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rdId;
    logic        rsp_err;
    logic [31:0] IO_mem_addr;
    logic [31:0] IO_mem_wdata;
    logic        IO_mem_wr;
    logic        IO_mem_rd;
    logic [31:0] IO_mem_rdata = '0;
    logic        IO_mem_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    // IO device model state
    int          io_delay = -1;
    int          strobe_cnt = 0;
    int          wr_cycles = 0;
    int          rd_cycles = 0;
    logic [31:0] io_addr_seen = '0;
    logic [31:0] io_wdata_seen = '0;

    logic [31:0] model_mem [RAM_WORDS];

    load_store_unit #(
        .RAM_WORDS  (RAM_WORDS),
        .IO_BIT     (IO_BIT),
        .IO_TIMEOUT (IO_TIMEOUT),
        .INIT_FILE  ("")
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_store    (req_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rdId     (req_rdId),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_rdId     (rsp_rdId),
        .rsp_err      (rsp_err),
        .IO_mem_addr  (IO_mem_addr),
        .IO_mem_wdata (IO_mem_wdata),
        .IO_mem_wr    (IO_mem_wr),
        .IO_mem_rd    (IO_mem_rd),
        .IO_mem_rdata (IO_mem_rdata),
        .IO_mem_ready (IO_mem_ready)
    );

    always #5 clk = ~clk;

    // IO device: raises ready during the io_delay-th strobe cycle (never if negative).
    always @(negedge clk) begin
        if (IO_mem_wr || IO_mem_rd) begin
            strobe_cnt = strobe_cnt + 1;
            if (IO_mem_wr) wr_cycles = wr_cycles + 1;
            if (IO_mem_rd) rd_cycles = rd_cycles + 1;
            io_addr_seen  = IO_mem_addr;
            io_wdata_seen = IO_mem_wdata;
            IO_mem_ready  = (io_delay > 0 && strobe_cnt == io_delay);
        end else begin
            strobe_cnt   = 0;
            IO_mem_ready = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks = checks + 1;
        assert (observed === expected) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] word);
        int sh;
        logic [31:0] v;
        sh = 8 * int'(a % 4);
        case (size_of(f3))
            1: begin
                v = (word >> sh) & 32'hFF;
                if (f3 == 3'd0 && v >= 32'd128) v = v | 32'hFFFFFF00;
            end
            2: begin
                v = (word >> sh) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'd32768) v = v | 32'hFFFF0000;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] a,
                                                input logic [31:0] word, input logic [31:0] wd);
        int sh;
        logic [31:0] keep;
        sh = 8 * int'(a % 4);
        case (size_of(f3))
            1: keep = 32'hFF << sh;
            2: keep = 32'hFFFF << sh;
            default: keep = 32'hFFFFFFFF;
        endcase
        return (word & ~keep) | ((wd << sh) & keep);
    endfunction

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        @(negedge clk);
        wr_cycles  = 0;
        rd_cycles  = 0;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_rdId   = rd;
        req_valid  = 1'b1;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk);
            #1 lat = lat + 1;
        end
    endtask

    // One full transaction with every response field checked against the model.
    task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int delay, input logic [31:0] iord,
                           output logic [31:0] got);
        logic        io;
        logic        mis;
        logic        exp_err;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_strobes;
        int          lat;
        logic [4:0]  rd;
        int          idx;
        io  = a[IO_BIT];
        mis = (a % size_of(f3)) != 0;
        idx = int'(a[9:2]);
        rd  = 5'($urandom_range(0, 31));
        exp_strobes = 0;
        if (mis) begin
            exp_err = 1'b1; exp_data = '0; exp_lat = 2;
        end else if (io) begin
            exp_strobes = (delay > 0 && delay <= IO_TIMEOUT) ? delay : IO_TIMEOUT;
            exp_err  = !(delay > 0 && delay <= IO_TIMEOUT);
            exp_data = (st || exp_err) ? 32'd0 : iord;
            exp_lat  = exp_strobes + 2;
        end else begin
            exp_err  = 1'b0;
            exp_data = st ? 32'd0 : model_load(f3, a, model_mem[idx]);
            exp_lat  = 2;
            if (st) model_mem[idx] = model_store(f3, a, model_mem[idx], wd);
        end
        io_delay     = delay;
        IO_mem_rdata = iord;
        issue(st, f3, a, wd, rd);
        wait_rsp(lat);
        check("latency", 32'(lat), 32'(exp_lat));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        check("rsp_data", rsp_data, exp_data);
        check("rsp_rdId", 32'(rsp_rdId), 32'(rd));
        check("wr_cycles", 32'(wr_cycles), st ? 32'(exp_strobes) : 32'd0);
        check("rd_cycles", 32'(rd_cycles), st ? 32'd0 : 32'(exp_strobes));
        if (exp_strobes > 0) begin
            check("io_addr", io_addr_seen, a);
            if (st) check("io_wdata", io_wdata_seen, wd);
        end
        got = rsp_data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] held;
        logic [31:0] a;
        int          lat;
        int          guard;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_rdId", 32'(rsp_rdId), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_io_wr", 32'(IO_mem_wr), 32'd0);
        check("rst_io_rd", 32'(IO_mem_rd), 32'd0);

        // Fill the working region (words 64..159) with known data
        for (int w = 64; w < 160; w++) begin
            run_txn(1'b1, 3'b010, 32'(w) << 2, $urandom, 0, 32'd0, got);
        end

        // Byte store and signed/unsigned byte loads
        run_txn(1'b1, 3'b000, 32'h103, 32'h123456A5, 0, 32'd0, got);
        run_txn(1'b0, 3'b100, 32'h103, 32'd0, 0, 32'd0, got);
        check("lbu_a5", got, 32'h000000A5);
        run_txn(1'b0, 3'b000, 32'h103, 32'd0, 0, 32'd0, got);
        check("lb_a5", got, 32'hFFFFFFA5);
        run_txn(1'b0, 3'b010, 32'h100, 32'd0, 0, 32'd0, got);
        check("lw_lane3", got[31:24], 32'hA5);

        // Halfword store into upper half
        held = model_mem[128];
        run_txn(1'b1, 3'b001, 32'h202, 32'h00008001, 0, 32'd0, got);
        run_txn(1'b0, 3'b010, 32'h200, 32'd0, 0, 32'd0, got);
        check("lw_sh", got, {16'h8001, held[15:0]});
        run_txn(1'b0, 3'b001, 32'h202, 32'd0, 0, 32'd0, got);
        check("lh_sh", got, 32'hFFFF8001);

        // Misaligned accesses
        run_txn(1'b0, 3'b010, 32'h102, 32'd0, 0, 32'd0, got);
        run_txn(1'b0, 3'b001, 32'h101, 32'd0, 0, 32'd0, got);
        run_txn(1'b1, 3'b010, 32'h105, 32'hFFFFFFFF, 0, 32'd0, got);
        run_txn(1'b1, 3'b101, 32'h00400003, 32'hFFFFFFFF, 0, 32'd0, got);
        run_txn(1'b0, 3'b010, 32'h104, 32'd0, 0, 32'd0, got);
        run_txn(1'b0, 3'b010, 32'h100, 32'd0, 0, 32'd0, got);

        // IO store with three wait cycles, IO load, IO timeout
        run_txn(1'b1, 3'b010, 32'h00400004, 32'hCAFEF00D, 3, 32'd0, got);
        run_txn(1'b0, 3'b010, 32'h00400008, 32'd0, 1, 32'hDEADBEEF, got);
        check("io_load", got, 32'hDEADBEEF);
        run_txn(1'b0, 3'b000, 32'h00400001, 32'd0, 2, 32'h89ABCDEF, got);
        run_txn(1'b0, 3'b010, 32'h0040000C, 32'd0, -1, 32'h11111111, got);
        run_txn(1'b1, 3'b010, 32'h00400010, 32'h5555AAAA, -1, 32'd0, got);

        // Back-pressure: response held, no new request accepted
        rsp_ready = 1'b0;
        issue(1'b0, 3'b010, 32'h200, 32'd0, 5'd7);
        wait_rsp(lat);
        check("bp_latency", 32'(lat), 32'd2);
        check("bp_data", rsp_data, model_mem[128]);
        held = rsp_data;
        req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h204; req_wdata = 32'h0BADF00D;
        req_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold", rsp_data, held);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", 32'(rsp_valid), 32'd0);
        check("bp_idle", 32'(req_ready), 32'd1);
        run_txn(1'b0, 3'b010, 32'h204, 32'd0, 0, 32'd0, got);

        // Asynchronous reset while the IO port is waiting
        io_delay = -1;
        issue(1'b0, 3'b010, 32'h00400020, 32'd0, 5'd3);
        guard = 0;
        while (!IO_mem_rd && guard < 5) begin
            @(posedge clk);
            #1 guard = guard + 1;
        end
        check("mid_rd_high", 32'(IO_mem_rd), 32'd1);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("arst_rd", 32'(IO_mem_rd), 32'd0);
        check("arst_wr", 32'(IO_mem_wr), 32'd0);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);
        check("post_rst_valid", 32'(rsp_valid), 32'd0);
        run_txn(1'b0, 3'b010, 32'h100, 32'd0, 0, 32'd0, got);

        // Random traffic against the model, with aliased upper RAM address bits
        for (int n = 0; n < 200; n++) begin
            logic       st;
            logic [2:0] f3;
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) begin
                a = 32'h00400000 | ($urandom & 32'h0000FFFF);
                run_txn(st, f3, a, $urandom, $urandom_range(0, 5), $urandom, got);
            end else begin
                a = (32'($urandom_range(0, 4095)) << 10) | (32'($urandom_range(64, 159)) << 2)
                    | 32'($urandom_range(0, 3));
                run_txn(st, f3, a, $urandom, 0, 32'd0, got);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
